// File: rtl/lumi_phy_link_model.sv
// Behavioural PHY link: in-order FIFO with per-beat age, programmable
// latency, pseudo-random receive stall injection and statistics.
module lumi_phy_link_model #(
    parameter int IOW   = 64,
    parameter int DEPTH = 8,
    parameter int LATW  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_en,
    input  logic [LATW-1:0]          csr_latency,
    input  logic                     csr_stall_en,
    input  logic [15:0]              csr_stall_seed,
    input  logic [IOW-1:0]           phy_txdata,
    input  logic                     phy_txvld,
    output logic                     phy_txrdy,
    output logic [IOW-1:0]           phy_rxdata,
    output logic                     phy_rxvld,
    input  logic                     phy_rxrdy,
    output logic [$clog2(DEPTH):0]   stat_level,
    output logic [31:0]              stat_beats,
    output logic [31:0]              stat_stall_cycles
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LATW-1:0] AGE_MAX = '1;

    logic [IOW-1:0]  mem [DEPTH];
    logic [LATW-1:0] age [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [LW-1:0]   level;
    logic [15:0]     lfsr;
    logic [15:0]     seed_fix;
    logic            lfsr_fb;
    logic            presented;
    logic            full;
    logic            empty;
    logic            head_elig;
    logic            stall;
    logic            push;
    logic            pop;

    assign seed_fix  = (csr_stall_seed == 16'h0) ? 16'h0001 : csr_stall_seed;
    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign head_elig = !empty && (age[rptr] >= csr_latency);

    // A beat already on the wire is never withdrawn by stall injection.
    assign stall = csr_stall_en && (lfsr[1:0] == 2'b00) && !presented;

    assign phy_txrdy  = !reset && csr_en && !full;
    assign phy_rxvld  = !reset && csr_en &&
                        (presented || (head_elig && !stall));
    assign phy_rxdata = mem[rptr];

    assign push = phy_txvld && phy_txrdy;
    assign pop  = phy_rxvld && phy_rxrdy;

    assign stat_level = level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= phy_txdata;
        end
    end

    // Ages run on every edge regardless of enable so a paused link
    // releases its backlog immediately once re-enabled.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wptr == PW'(i))) begin
                age[i] <= '0;
            end else if (age[i] != AGE_MAX) begin
                age[i] <= age[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr              <= '0;
            rptr              <= '0;
            level             <= '0;
            presented         <= 1'b0;
            stat_beats        <= '0;
            stat_stall_cycles <= '0;
            lfsr              <= seed_fix;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            presented <= phy_rxvld && !phy_rxrdy;
            if (pop) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if (csr_en && head_elig && stall) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            if (csr_stall_en) begin
                lfsr <= {lfsr[14:0], lfsr_fb};
            end else begin
                lfsr <= seed_fix;
            end
        end
    end

endmodule

// File: doc/lumi_phy_link_model.md
LUMI_PHY_LINK_MODEL -- requirements
Module: lumi_phy_link_model

Interface
REQ-001 SHALL have parameter IOW, default 64: PHY data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: in-flight beat capacity; power of two, >=2.
REQ-003 SHALL have parameter LATW, default 4: width of latency setting and per-entry age counter.
REQ-004 SHALL have ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- csr_en  in  1  link enable
- csr_latency  in  LATW  extra link delay in cycles
- csr_stall_en  in  1  enable pseudo-random receive stalls
- csr_stall_seed  in  16  LFSR seed
- phy_txdata  in  IOW  transmit beat
- phy_txvld  in  1  transmit beat valid
- phy_txrdy  out  1  link can accept a beat
- phy_rxdata  out  IOW  delivered beat
- phy_rxvld  out  1  delivered beat valid
- phy_rxrdy  in  1  receiver accepts beat
- stat_level  out  $clog2(DEPTH)+1  entries in flight
- stat_beats  out  32  beats delivered
- stat_stall_cycles  out  32  cycles an eligible beat was withheld by stall injection

Function
REQ-005 SHALL store accepted beats in a DEPTH-entry FIFO, in order; each entry holds data and an LATW-bit age.
REQ-006 SHALL accept a beat on a rising edge where phy_txvld & phy_txrdy.
REQ-007 SHALL drive phy_txrdy = csr_en & (stat_level != DEPTH), with no combinational path from phy_rxrdy; a full FIFO refuses the beat even when a pop occurs in the same cycle.
REQ-008 SHALL set an entry's age to 0 on capture and increment it on every edge thereafter, saturating at 2^LATW-1, including while csr_en=0.
REQ-009 SHALL define head-eligible as FIFO non-empty & head age >= csr_latency.
REQ-010 SHALL drive phy_rxvld = csr_en & head-eligible & !stall, and phy_rxdata = head data; phy_rxdata is don't-care when phy_rxvld=0.
REQ-011 SHALL pop the head on a rising edge where phy_rxvld & phy_rxrdy.
REQ-012 SHALL yield a minimum latency of csr_latency+1 cycles from the accept edge to the first cycle phy_rxvld can be high; latency 0 means visible in the cycle after the accept edge.
REQ-013 SHALL make a csr_latency change take effect in the same cycle against the existing ages, and SHALL never reorder beats.
REQ-014 SHALL support simultaneous push and pop, leaving stat_level unchanged; pointers wrap modulo DEPTH.
REQ-015 SHALL hold phy_rxvld and phy_rxdata stable once asserted until the handshake completes, unless csr_en falls; stall affects only the decision to first present a beat.
REQ-016 SHALL use a 16-bit Fibonacci LFSR with taps 16,14,13,11.
- While csr_stall_en=0 the LFSR loads csr_stall_seed each edge, substituting 16'h0001 for a zero seed.
- While csr_stall_en=1 it advances one step per edge.
REQ-017 SHALL assert stall when csr_stall_en & LFSR[1:0]==2'b00 and no beat is currently presented.
REQ-018 SHALL increment stat_stall_cycles, wrapping, on each edge where csr_en & head-eligible & stall.
REQ-019 SHALL increment stat_beats, wrapping at 2^32, on each rx handshake.
REQ-020 SHALL, when csr_en=0, hold phy_txrdy=0 and phy_rxvld=0 and retain FIFO contents.

Reset
REQ-021 SHALL, with reset high on an edge:
- empty the FIFO
- clear stat_level, stat_beats and stat_stall_cycles to 0
- load the LFSR with the seed per REQ-016
- drive phy_txrdy=0 and phy_rxvld=0 during reset
REQ-022 SHALL let reset asserted mid-transfer discard all in-flight beats with no output beat after release; the first beat accepted after release is the first delivered.

Verification
REQ-023 Scenario: csr_en=1, latency=3, stall off, rxrdy=1, push 0xA5 at edge k -> phy_rxvld first high in cycle after edge k+3; stat_beats=1.
REQ-024 Scenario: rxrdy=0, push 8 beats back-to-back -> txrdy low after 8th accept, stat_level=8; raise rxrdy -> 8 beats out in order; txrdy returns the cycle after first pop.
REQ-025 Scenario: latency=0, stream 100 beats with txvld and rxrdy always 1 -> one beat per cycle after first, stat_level steady at 1, stat_beats=100.
REQ-026 Scenario: stall_en=1, seed=0xACE1, 1000 random beats, random rxrdy -> output sequence equals input sequence; stat_stall_cycles equals a reference LFSR model count; rxvld never drops without a handshake.
REQ-027 Scenario: 5 beats in flight, reset pulsed 1 cycle -> stat_level=0, no stale beat emitted; next pushed beat 0x1234 is the first delivered.
REQ-028 Scenario: csr_en dropped with 3 beats queued for 10 cycles -> txrdy=0, rxvld=0 throughout; after re-enable, 3 beats emitted immediately in order (ages saturated past latency).
